cc_read_scheduler: RTL
======================

# cc_read_scheduler

Sequencing controller in front of the cache controller's data reorder unit. It accepts tag-lookup results one at a time, in order. Each hit writes a hit flag of 1 and a 518-bit hit data entry into the reorder unit's FIFOs. Each miss writes a hit flag of 0 and issues one 8-beat AXI read burst to memory. The block applies back-pressure from the FIFO almost-full flags and from a limit on outstanding memory bursts.

## Interface
- ADDR_WIDTH, 32, request address width
- MAX_OUTSTANDING, 4, maximum memory bursts in flight (1..15)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- lookup_valid_i  in  1  lookup result valid
- lookup_ready_o  out  1  lookup result accepted when valid&ready
- lookup_hit_i  in  1  1 = hit, 0 = miss
- lookup_addr_i  in  ADDR_WIDTH  request address
- lookup_data_i  in  512  cache line (hit only)
- lookup_offset_i  in  6  byte offset of critical word
- hit_flag_fifo_afull_i  in  1  flag FIFO almost full
- hit_flag_fifo_wren_o  out  1  flag FIFO write
- hit_flag_fifo_wdata_o  out  1  flag value
- hit_data_fifo_afull_i  in  1  data FIFO almost full
- hit_data_fifo_wren_o  out  1  data FIFO write
- hit_data_fifo_wdata_o  out  518  {offset[5:0], line[511:0]}
- mem_araddr_o  out  ADDR_WIDTH  burst address, bits [5:0] = 0
- mem_arlen_o  out  4  constant 7
- mem_arsize_o  out  3  constant 3 (8 bytes)
- mem_arburst_o  out  2  constant 1 (INCR)
- mem_arvalid_o  out  1  AR valid
- mem_arready_i  in  1  AR ready
- mem_rlast_i, mem_rvalid_i, mem_rready_i  in  1 each  R-channel snoop, used only for burst retirement
- outstanding_o  out  4  bursts in flight

## Operation
- FSM states:
  - IDLE: accepting lookups.
  - AR_REQ: miss burst pending on AR.
- lookup_ready_o is 1 only when all of the following hold:
  - state = IDLE
  - rst = 0
  - !hit_flag_fifo_afull_i
  - !hit_data_fifo_afull_i
  - outstanding < MAX_OUTSTANDING
- lookup_ready_o does not depend on lookup_hit_i.
- Accepted hit:
  - next cycle: hit_flag_fifo_wren_o = 1 with wdata = 1.
  - same next cycle: hit_data_fifo_wren_o = 1 with wdata = {lookup_offset_i, lookup_data_i} as registered at accept.
  - state stays IDLE.
- Accepted miss:
  - next cycle: hit_flag_fifo_wren_o = 1 with wdata = 0; no data write.
  - mem_araddr_o is loaded with {lookup_addr_i[ADDR_WIDTH-1:6], 6'b0}.
  - state moves to AR_REQ.
- AR_REQ:
  - mem_arvalid_o = 1; araddr is held stable until mem_arready_i.
  - On handshake: state goes to IDLE and outstanding increments.
- Retirement: outstanding decrements on mem_rvalid_i & mem_rready_i & mem_rlast_i.
- Simultaneous AR handshake and retirement: outstanding unchanged.
- Hit flags are written strictly in acceptance order, so the reorder unit's selector sees the program order of hits and misses.
- Counter width 4 bits; the acceptance rule keeps it from exceeding MAX_OUTSTANDING. A retirement at 0 is a protocol error: the counter saturates at 0.

## Timing
- Reset values:
  - state = IDLE, outstanding_o = 0, mem_arvalid_o = 0, mem_araddr_o = 0.
  - both FIFO wren = 0, both wdata = 0, lookup_ready_o = 0.
- Reset mid-burst: arvalid drops the cycle after rst is sampled high; any pending FIFO write is cancelled; outstanding is cleared.
- Latency:
  - accept at cycle T gives FIFO writes at T+1.
  - a miss accepted at T raises mem_arvalid_o at T+1.
- Throughput:
  - hits: 1 per cycle while afull flags stay low.
  - miss: blocks acceptance from T+1 until the cycle after its AR handshake. With mem_arready_i held high, the next accept is at T+2.
- Almost-full flags are sampled in the accept cycle. The single registered write in flight must fit in the FIFO's afull headroom; integration guarantees at least 1 entry.
- outstanding_o is updated one cycle after the AR handshake or retirement.

## Test plan
- Four back-to-back hits, afull low, offsets 0x08/0x10/0x18/0x20:
  - flag writes 1,1,1,1 on consecutive cycles T+1..T+4.
  - data writes carry the matching offsets.
  - lookup_ready_o stays 1.
- Miss at addr 0x0000_1234 with arready held 0 for 3 cycles:
  - flag write 0 at T+1.
  - arvalid 1 from T+1, araddr = 0x0000_1200, arlen = 7.
  - ready low until the cycle after the handshake.
  - outstanding 0→1.
- Five misses with no R beats returned:
  - four AR bursts issued; outstanding = 4.
  - fifth miss is held (ready = 0).
  - one rlast handshake makes outstanding 3; the fifth miss is then accepted.
- AR handshake and rlast beat in the same cycle with outstanding = 2: outstanding stays 2.
- hit_data_fifo_afull_i = 1 while a hit is valid: no accept and no writes; the accept happens in the cycle the flag drops.
- rst asserted during AR_REQ: next cycle arvalid = 0 and outstanding = 0; after release, a new miss issues normally.

Source files
------------

// File: rtl/cc_read_scheduler_if.sv
// Bundle of the lookup, reorder-FIFO, and memory AR/R-snoop signals of the
// read scheduler. The slave side is the scheduler; the master side is its environment.
interface cc_read_scheduler_if #(
  parameter int ADDR_WIDTH = 32
);
  // lookup result channel
  logic                  lookup_valid_i;
  logic                  lookup_ready_o;
  logic                  lookup_hit_i;
  logic [ADDR_WIDTH-1:0] lookup_addr_i;
  logic [511:0]          lookup_data_i;
  logic [5:0]            lookup_offset_i;
  // reorder unit FIFOs
  logic                  hit_flag_fifo_afull_i;
  logic                  hit_flag_fifo_wren_o;
  logic                  hit_flag_fifo_wdata_o;
  logic                  hit_data_fifo_afull_i;
  logic                  hit_data_fifo_wren_o;
  logic [517:0]          hit_data_fifo_wdata_o;
  // memory AR channel
  logic [ADDR_WIDTH-1:0] mem_araddr_o;
  logic [3:0]            mem_arlen_o;
  logic [2:0]            mem_arsize_o;
  logic [1:0]            mem_arburst_o;
  logic                  mem_arvalid_o;
  logic                  mem_arready_i;
  // memory R channel snoop
  logic                  mem_rlast_i;
  logic                  mem_rvalid_i;
  logic                  mem_rready_i;
  // status
  logic [3:0]            outstanding_o;

  modport slave (
    input  lookup_valid_i, lookup_hit_i, lookup_addr_i, lookup_data_i, lookup_offset_i,
    input  hit_flag_fifo_afull_i, hit_data_fifo_afull_i,
    input  mem_arready_i, mem_rlast_i, mem_rvalid_i, mem_rready_i,
    output lookup_ready_o,
    output hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o,
    output hit_data_fifo_wren_o, hit_data_fifo_wdata_o,
    output mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o, mem_arvalid_o,
    output outstanding_o
  );

  modport master (
    output lookup_valid_i, lookup_hit_i, lookup_addr_i, lookup_data_i, lookup_offset_i,
    output hit_flag_fifo_afull_i, hit_data_fifo_afull_i,
    output mem_arready_i, mem_rlast_i, mem_rvalid_i, mem_rready_i,
    input  lookup_ready_o,
    input  hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o,
    input  hit_data_fifo_wren_o, hit_data_fifo_wdata_o,
    input  mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o, mem_arvalid_o,
    input  outstanding_o
  );
endinterface

// File: rtl/cc_read_scheduler.sv
// Read scheduler in front of the reorder unit: turns in-order lookup results
// into hit-flag/hit-data FIFO writes and 8-beat AXI INCR read bursts for misses,
// throttled by FIFO almost-full flags and an outstanding-burst limit.
module cc_read_scheduler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               rst,
  cc_read_scheduler_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_AR_REQ = 1'b1
  } state_e;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_e                state_q, state_d;
  logic [3:0]            outstanding_q, outstanding_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  flag_wren_q, flag_wren_d;
  logic                  flag_wdata_q, flag_wdata_d;
  logic                  data_wren_q, data_wren_d;
  logic [517:0]          data_wdata_q, data_wdata_d;

  logic ready_s;
  logic accept_s;
  logic ar_hs_s;
  logic retire_s;
  logic unused_addr_s;

  // Bursts are line aligned, so the byte offset bits of the address are dropped.
  assign unused_addr_s = ^bus.lookup_addr_i[5:0];

  // Ready is a function of state and back-pressure only, never of hit/miss.
  assign ready_s  = (state_q == ST_IDLE) && !rst &&
                    !bus.hit_flag_fifo_afull_i && !bus.hit_data_fifo_afull_i &&
                    (outstanding_q < MAX_OUT);
  assign accept_s = bus.lookup_valid_i && ready_s;
  assign ar_hs_s  = (state_q == ST_AR_REQ) && bus.mem_arready_i;
  assign retire_s = bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i;

  // Next-state and FIFO write / AR address computation.
  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    flag_wren_d  = 1'b0;
    flag_wdata_d = flag_wdata_q;
    data_wren_d  = 1'b0;
    data_wdata_d = data_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          flag_wren_d  = 1'b1;
          flag_wdata_d = bus.lookup_hit_i;
          if (bus.lookup_hit_i) begin
            data_wren_d  = 1'b1;
            data_wdata_d = {bus.lookup_offset_i, bus.lookup_data_i};
          end else begin
            araddr_d = {bus.lookup_addr_i[ADDR_WIDTH-1:6], 6'b000000};
            state_d  = ST_AR_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR_REQ: begin
        if (bus.mem_arready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_AR_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outstanding-burst counter; issue and retirement in one cycle cancel out,
  // and a stray retirement at zero leaves the counter at zero.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({ar_hs_s, retire_s})
      2'b10: begin
        outstanding_d = outstanding_q + 4'd1;
      end
      2'b01: begin
        if (outstanding_q != 4'd0) begin
          outstanding_d = outstanding_q - 4'd1;
        end else begin
          outstanding_d = 4'd0;
        end
      end
      default: begin
        outstanding_d = outstanding_q;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      outstanding_q <= 4'd0;
      araddr_q      <= '0;
      flag_wren_q   <= 1'b0;
      flag_wdata_q  <= 1'b0;
      data_wren_q   <= 1'b0;
      data_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      araddr_q      <= araddr_d;
      flag_wren_q   <= flag_wren_d;
      flag_wdata_q  <= flag_wdata_d;
      data_wren_q   <= data_wren_d;
      data_wdata_q  <= data_wdata_d;
    end
  end

  assign bus.lookup_ready_o        = ready_s;
  assign bus.hit_flag_fifo_wren_o  = flag_wren_q;
  assign bus.hit_flag_fifo_wdata_o = flag_wdata_q;
  assign bus.hit_data_fifo_wren_o  = data_wren_q;
  assign bus.hit_data_fifo_wdata_o = data_wdata_q;
  assign bus.mem_araddr_o          = araddr_q;
  assign bus.mem_arlen_o           = 4'd7;
  assign bus.mem_arsize_o          = 3'd3;
  assign bus.mem_arburst_o         = 2'd1;
  assign bus.mem_arvalid_o         = (state_q == ST_AR_REQ);
  assign bus.outstanding_o         = outstanding_q;

endmodule
